// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter onto a single ready-handshake slave
// Optional slave watchdog: define MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            s_req,
    output logic            s_we,
    output logic [DW/8-1:0] s_be,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ready,
    output logic            busy
);

    localparam int BW = DW / 8;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT out of range 1..255");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            s_req_q, s_req_d;
    logic            s_we_q, s_we_d;
    logic [BW-1:0]   s_be_q, s_be_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
    logic            m0_ack_q, m0_ack_d;
    logic            m1_ack_q, m1_ack_d;
    logic            busy_q, busy_d;
    logic            sel;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      cnt_q, cnt_d;
    logic            m0_err_q, m0_err_d;
    logic            m1_err_q, m1_err_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_be_q       <= '0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            cnt_q        <= '0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_be_q       <= s_be_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            busy_q       <= busy_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            cnt_q        <= cnt_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_be_d       = s_be_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        // On a tie, master 1 wins only if master 0 was granted last.
        sel          = m1_req && (!m0_req || !last_grant_q);
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        cnt_d        = cnt_q;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    s_req_d      = 1'b1;
                    s_we_d       = sel ? m1_we    : m0_we;
                    s_be_d       = sel ? m1_be    : m0_be;
                    s_addr_d     = sel ? m1_addr  : m0_addr;
                    s_wdata_d    = sel ? m1_wdata : m0_wdata;
                    state_d      = BUSY;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            BUSY: begin
                if (s_ready) begin
                    if (grant_q) begin
                        m1_rdata_d = s_rdata;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = s_rdata;
                        m0_ack_d   = 1'b1;
                    end
                    s_req_d = 1'b0;
                    state_d = RESP;
                end else begin
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        m0_ack_d = !grant_q;
                        m0_err_d = !grant_q;
                        m1_ack_d = grant_q;
                        m1_err_d = grant_q;
                        s_req_d  = 1'b0;
                        state_d  = RESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_be     = s_be_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign busy     = busy_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data-side peripheral bus behind the memory stage.
- Master 0 is the CPU memory-stage bridge port; master 1 is the debug/DMA loader port.
- Serialises accesses, round-robin on contention, holds the slave request until the slave reports ready, and returns read data with a one-cycle ack.
- Optional watchdog aborts hung slave accesses.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8)
- TIMEOUT, 15, max BUSY cycles waiting for s_ready before abort (TIMEOUT_EN only); legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0 write
- m0_be  in  DW/8  master 0 byte enables
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_rdata  out  DW  read data to master 0, valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  timeout flag, valid with m0_ack
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: identical to master 0
- s_req  out  1  slave request
- s_we  out  1  slave write
- s_be  out  DW/8  slave byte enables
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  slave read data, sampled when s_ready=1
- s_ready  in  1  slave completion, sampled only while s_req=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Internal state resets to IDLE, timeout counter to 0, last_grant to 1 (so master 0 wins the first tie).
- States:
  - IDLE: sample m0_req/m1_req. Arbitration:
    - neither request: stay in IDLE.
    - one request: grant it.
    - both: grant the master that is not last_grant.
    - On grant: latch that master's we/be/addr/wdata into s_* registers, set s_req=1, record grant, set last_grant=grant, clear counter, go to BUSY.
  - BUSY: hold all s_* outputs stable.
    - If s_ready=1 at the clock edge: latch s_rdata into the granted master's rdata, pulse its ack=1 (err=0), drop s_req, go to RESP.
    - Else increment counter.
  - RESP: ack high for exactly this one cycle; next edge clears ack and returns to IDLE. No arbitration happens in RESP (one bubble per transfer).
- Latency:
  - req high at edge k, so s_req high after edge k+1.
  - If s_ready=1 in that cycle, ack is high after edge k+2.
  - Minimum of 3 cycles from request to re-arbitration.
- Masters keep req and payload stable until they see ack. A master must drop req in the cycle it sees ack, or it is treated as a new request in the following IDLE.
- rdata holds its last value until the next ack to the same master. On writes it is loaded with s_rdata (don't-care).
- The non-granted master's ack and err stay 0. Its req is ignored until the next IDLE.
- A request that arrives while busy is served in the next IDLE. Round-robin guarantees it waits at most one transfer.
- Reset asserted mid-BUSY: s_req drops immediately (asynchronous), no ack is issued, and the transaction is lost.
- s_ready outside BUSY is ignored.
- Payload changes on a master during BUSY have no effect (the payload is latched).

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In BUSY, when the counter reaches TIMEOUT-1 with s_ready still 0, the next edge drops s_req, sets the granted master's ack=1 and err=1, leaves rdata unchanged, and goes to RESP.
  - s_ready=1 on that same edge wins: normal completion with err=0.
- Undefined: no counter; BUSY waits indefinitely; m0_err and m1_err are tied 0.

Test Plan:
- Single read, m0_addr=0x7F00, s_ready tied 1, s_rdata=0xDEADBEEF -> s_req high 1 cycle later with s_addr=0x7F00, s_we=0; m0_ack for 1 cycle, 2 cycles after req, with m0_rdata=0xDEADBEEF; busy clears after RESP.
- Simultaneous m0/m1 writes right after reset (m0_addr=0x7F04, m0_wdata=0x11; m1_addr=0x7F08, m1_wdata=0x22) -> m0 served first, then m1. Repeat both requests -> m0 served first again, because last_grant toggles.
- Slave wait states, s_ready low for 4 BUSY cycles then high -> s_* stable for all 5 cycles; single ack; m1_ack never pulses.
- Reset pulsed for 1 cycle during BUSY of an m1 read -> s_req=0 asynchronously; no m1_ack; next m0 request is granted normally from IDLE.
- TIMEOUT_EN with TIMEOUT=15, s_ready held 0 -> m0_ack=1 and m0_err=1 exactly 15 cycles after s_req rose; s_req low; m0_rdata unchanged.
- TIMEOUT_EN with s_ready rising on the 15th BUSY cycle -> m0_err=0 and read data returned.
